// File: rtl/noc_credit_tx_port.sv
// Credit-based NoC transmit port: launches flits only against downstream credits,
// registers them onto the link and watches head/tail framing of the outgoing stream.
module noc_credit_tx_port #(
    parameter int DataWidth      = 64,
    parameter int PortQueueDepth = 5,
    parameter int CreditsWidth   = $clog2(PortQueueDepth + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DataWidth-1:0]    flit_in,
    input  logic                    flit_in_valid,
    output logic                    flit_in_ready,
    output logic [DataWidth-1:0]    data_out,
    output logic                    data_void_out,
    input  logic                    credit_in,
    output logic [CreditsWidth-1:0] credits_o,
    output logic                    in_packet_o,
    output logic                    framing_error_o
);
    localparam logic [CreditsWidth-1:0] MaxCredits = CreditsWidth'(PortQueueDepth);
    localparam logic [CreditsWidth-1:0] OneCredit  = CreditsWidth'(1);

    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } state_t;

    state_t                  state_reg, state_next;
    logic [CreditsWidth-1:0] credits_reg, credits_next;
    logic [DataWidth-1:0]    data_reg;
    logic                    void_reg;
    logic                    error_reg, error_next;
    logic                    accept, head, tail, overflow, frame_error;

    assign head          = flit_in[DataWidth-1];
    assign tail          = flit_in[DataWidth-2];
    assign flit_in_ready = (credits_reg != '0);
    assign accept        = flit_in_valid & flit_in_ready;
    // A returned credit with a full counter and nothing launched means the
    // downstream queue freed a slot we never filled.
    assign overflow      = credit_in & ~accept & (credits_reg == MaxCredits);

    always_comb begin
        credits_next = credits_reg;
        if (accept && !credit_in) begin
            credits_next = credits_reg - OneCredit;
        end else if (!accept && credit_in && !overflow) begin
            credits_next = credits_reg + OneCredit;
        end
    end

    // Framing FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Framing FSM: next state (a head seen in BODY restarts the packet)
    always_comb begin
        state_next = state_reg;
        if (accept) begin
            case (state_reg)
                IDLE:    state_next = (head && !tail) ? BODY : IDLE;
                BODY:    state_next = tail ? IDLE : BODY;
                default: state_next = IDLE;
            endcase
        end
    end

    // Framing FSM: outputs
    always_comb begin
        in_packet_o = (state_reg == BODY);
        frame_error = 1'b0;
        if (accept) begin
            frame_error = (state_reg == IDLE) ? ~head : head;
        end
    end

    assign error_next = error_reg | frame_error | overflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            credits_reg <= MaxCredits;
            data_reg    <= '0;
            void_reg    <= 1'b1;
            error_reg   <= 1'b0;
        end else begin
            credits_reg <= credits_next;
            void_reg    <= ~accept;
            error_reg   <= error_next;
            if (accept) begin
                data_reg <= flit_in;
            end
        end
    end

    assign data_out        = data_reg;
    assign data_void_out   = void_reg;
    assign credits_o       = credits_reg;
    assign framing_error_o = error_reg;

endmodule

// File: tb/tb_noc_credit_tx_port.sv
// Self-checking bench for noc_credit_tx_port: table of per-cycle vectors plus
// hand-written corner sequences, with a scoreboard queue for the flit stream.
module tb_noc_credit_tx_port;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] flit_in = '0;
    logic        flit_in_valid = 1'b0;
    logic        flit_in_ready;
    logic [63:0] data_out;
    logic        data_void_out;
    logic        credit_in = 1'b0;
    logic [2:0]  credits_o;
    logic        in_packet_o;
    logic        framing_error_o;

    noc_credit_tx_port dut (
        .clk             (clk),
        .rst             (rst),
        .flit_in         (flit_in),
        .flit_in_valid   (flit_in_valid),
        .flit_in_ready   (flit_in_ready),
        .data_out        (data_out),
        .data_void_out   (data_void_out),
        .credit_in       (credit_in),
        .credits_o       (credits_o),
        .in_packet_o     (in_packet_o),
        .framing_error_o (framing_error_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [1:0] pre;
        logic       ci;
        logic [2:0] cr;
        logic       vd;
        logic       inp;
        logic       err;
    } vec_t;

    vec_t        tbl[$];
    logic [63:0] sb[$];
    logic [63:0] last_data;
    logic [2:0]  prev_cr;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flit_in_valid = 1'b0;
        credit_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        last_data = '0;
        prev_cr = 3'd5;
        chk("rst_credits", 64'(credits_o), 64'd5);
        chk("rst_void", 64'(data_void_out), 64'd1);
        chk("rst_in_packet", 64'(in_packet_o), 64'd0);
        chk("rst_error", 64'(framing_error_o), 64'd0);
        chk("rst_ready", 64'(flit_in_ready), 64'd1);
        chk("rst_data", data_out, 64'd0);
        $display("reset: credits=%0d void=%0b in_packet=%0b err=%0b",
                 credits_o, data_void_out, in_packet_o, framing_error_o);
    endtask

    // Drive one cycle of inputs, then check the registered outputs it produces.
    task automatic step(input logic v, input logic [1:0] pre, input logic ci,
                        input logic [2:0] ecr, input logic evd, input logic einp,
                        input logic eerr);
        logic [63:0] r;
        logic [63:0] exp_flit;
        r = {$urandom(), $urandom()};
        flit_in = {pre, r[61:0]};
        flit_in_valid = v;
        credit_in = ci;
        if (v && prev_cr != 3'd0) sb.push_back(flit_in);
        @(posedge clk);
        @(negedge clk);
        flit_in_valid = 1'b0;
        credit_in = 1'b0;
        chk("credits", 64'(credits_o), 64'(ecr));
        chk("void", 64'(data_void_out), 64'(evd));
        chk("in_packet", 64'(in_packet_o), 64'(einp));
        chk("error", 64'(framing_error_o), 64'(eerr));
        chk("ready", 64'(flit_in_ready), 64'(ecr != 3'd0));
        if (!data_void_out) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_flit", data_out, 64'hx);
            end else begin
                exp_flit = sb.pop_front();
                chk("data_order", data_out, exp_flit);
                last_data = exp_flit;
            end
        end else begin
            chk("data_hold", data_out, last_data);
        end
        prev_cr = ecr;
        $display("cyc v=%0b pre=%02b ci=%0b -> credits=%0d void=%0b in_pkt=%0b err=%0b data=%0h",
                 v, pre, ci, credits_o, data_void_out, in_packet_o, framing_error_o, data_out);
    endtask

    initial begin
        // 1: five single-flit packets drain all credits
        for (int i = 0; i < 5; i++) tbl.push_back('{1'b1, 2'b11, 1'b0, 3'(4 - i), 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 2'b11, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0});
        // 2: one returned credit re-enables exactly one launch
        tbl.push_back('{1'b1, 2'b11, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 2'b11, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 2'b11, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0});
        // 3: refill to 3, then accept and credit together hold the count
        for (int i = 0; i < 3; i++) tbl.push_back('{1'b0, 2'b00, 1'b1, 3'(i + 1), 1'b1, 1'b0, 1'b0});
        for (int i = 0; i < 4; i++) tbl.push_back('{1'b1, 2'b11, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0});
        // 4: head, body, body, tail
        tbl.push_back('{1'b1, 2'b10, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 2'b00, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 2'b00, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 2'b01, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 2'b00, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0});

        repeat (2) @(posedge clk);
        do_reset();
        foreach (tbl[i]) step(tbl[i].v, tbl[i].pre, tbl[i].ci, tbl[i].cr, tbl[i].vd, tbl[i].inp, tbl[i].err);

        // 5: body flit while idle is flagged but still forwarded
        step(1'b1, 2'b00, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1);
        do_reset();
        step(1'b1, 2'b10, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0);
        step(1'b1, 2'b10, 1'b0, 3'd3, 1'b0, 1'b1, 1'b1);
        step(1'b1, 2'b11, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1);

        // 6: full counter with accept+credit is legal; bare credit overflows
        do_reset();
        step(1'b1, 2'b11, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
        step(1'b0, 2'b00, 1'b1, 3'd5, 1'b1, 1'b0, 1'b1);
        step(1'b1, 2'b10, 1'b0, 3'd4, 1'b0, 1'b1, 1'b1);
        do_reset();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/noc_credit_tx_port.md
Name: noc_credit_tx_port

Overview:
- Transmit side of the credit-based NoC link. It drives flits into a downstream router input queue of depth PortQueueDepth.
- It keeps a credit counter that mirrors free slots in that queue. It only launches a flit when a credit is available and consumes the credit on launch; the downstream queue returns one credit per freed slot.
- It also checks head/tail packet framing on the outgoing stream and reports violations.
- Instantiated between a local source (tile, or a router output arbiter) and one router input port.

Parameters:
- DataWidth, 64, flit width. Bits [DataWidth-1:DataWidth-2] carry the preamble {head, tail}.
- PortQueueDepth, 5, downstream queue depth; initial and maximum credit count.
- CreditsWidth, $clog2(PortQueueDepth+1), credit counter width (3 at default).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- flit_in  input  DataWidth  flit from local source.
- flit_in_valid  input  1  flit_in holds a flit.
- flit_in_ready  output  1  port can accept flit_in this cycle.
- data_out  output  DataWidth  flit on link to downstream input queue.
- data_void_out  output  1  high = no flit on data_out this cycle.
- credit_in  input  1  one-cycle pulse = one downstream slot freed.
- credits_o  output  CreditsWidth  current credit count.
- in_packet_o  output  1  high between an accepted head flit and its tail.
- framing_error_o  output  1  sticky framing/credit error flag.

Behaviour:
- Reset (synchronous, active-high): credits = PortQueueDepth, data_out = 0, data_void_out = 1, FSM = IDLE, in_packet_o = 0, framing_error_o = 0. Reset mid-packet discards framing state.
- flit_in_ready = (credits != 0). Purely from registered state; there is no bypass from credit_in.
- Accept when flit_in_valid & flit_in_ready.
- Latency is 1 cycle. On accept, next cycle: data_out = flit_in, data_void_out = 0.
- With no accept, next cycle: data_void_out = 1 and data_out holds its previous value.
- At most one flit per cycle; back-to-back accepts are allowed while credits remain.
- Credit update per cycle: credits_next = credits - accept + credit_in.
  - accept and credit_in together: count unchanged.
  - credits == 0: ready low. A credit_in raises credits to 1 and ready goes high the next cycle.
  - credit_in with credits == PortQueueDepth and no accept: overflow. Count stays at PortQueueDepth and framing_error_o is set.
  - Underflow cannot occur, since accept requires credits != 0.
- Framing FSM (advances only on accept), states IDLE and BODY:
  - IDLE, head=1 tail=1: single-flit packet; stay IDLE.
  - IDLE, head=1 tail=0: go to BODY; in_packet_o = 1 from the next cycle.
  - IDLE, head=0: set framing_error_o, stay IDLE. The flit is still forwarded.
  - BODY, head=0 tail=0: stay BODY.
  - BODY, head=0 tail=1: go to IDLE; in_packet_o = 0 from the next cycle.
  - BODY, head=1: set framing_error_o. Treat the flit as a new head: if its tail=1, go to IDLE, else stay BODY.
- in_packet_o = (FSM == BODY).
- framing_error_o clears only on rst.
- No flit is ever dropped or reordered; errors are report-only.

Test Plan:
1. Reset, then 5 single-flit packets (head=tail=1) back-to-back with no credit_in. Expect data_void_out low for 5 consecutive cycles starting 1 cycle after the first accept, credits_o 5→0, flit_in_ready low after the 5th, no error.
2. From credits=0, pulse credit_in once with flit_in_valid held. Expect credits_o=1 next cycle, accept in that cycle, credits_o back to 0, one flit on data_out one cycle after accept.
3. Credits=3, accept and credit_in in the same cycle for 4 cycles. Expect credits_o stays 3 and 4 flits out in order.
4. Send head, body, body, tail (preamble 10, 00, 00, 01). Expect in_packet_o high for exactly 3 cycles starting the cycle after the head accept, FSM back to IDLE, framing_error_o stays 0.
5. Framing errors: in IDLE send body flit (00), expect framing_error_o=1 next cycle and the flit still on data_out. Then rst, send head (10) followed by head (10), expect error set and in_packet_o remains 1.
6. Credit overflow: at reset (credits=5), pulse credit_in. Expect credits_o stays 5 and framing_error_o=1. Assert rst mid-packet: expect credits_o=5, data_void_out=1, in_packet_o=0, error cleared.
